// File: rtl/pkt_arb_pkg.sv
// Shared types and beat-field helpers for the packet round-robin arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pkt_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    ABORT = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Beat layout: MSB is tuser (abort marker), next bit down is tlast.
  function automatic int tuser_bit(input int d_width);
    return d_width - 1;
  endfunction

  function automatic int tlast_bit(input int d_width);
    return d_width - 2;
  endfunction

  // Abort beat: tuser=1, tlast=1, payload zero. Returned wide; callers take
  // the low d_width bits.
  function automatic logic [63:0] abort_beat(input int d_width);
    logic [63:0] b;
    b = '0;
    b[d_width-1] = 1'b1;
    b[d_width-2] = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/pkt_len_watchdog.sv
// Per-packet beat counter with clear, increment and "limit reached" flag.
// Latency: count updates one cycle after inc_i; ovf_o is combinational.
// Backpressure: none; caller only pulses inc_i on real transfers.
module pkt_len_watchdog #(
  parameter int MAX_PKT_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic ovf_o
);

  localparam int CW = $clog2(MAX_PKT_LEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_PKT_LEN - 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_PKT_LEN);

  logic [CW-1:0] cnt_q, cnt_d;

  // Flag the increment that makes the count equal MAX_PKT_LEN.
  assign ovf_o = inc_i && (cnt_q == LAST_CNT);

  // Next count: clear wins, increment never wraps past the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_CNT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pkt_rr_arb_rollback.sv
// Two-source packet round-robin arbiter with max-length abort injection
// (optional stats counters under PKT_ARB_STATS_EN).
// Latency: combinational pass-through in PASS; one idle bubble per packet.
// Backpressure: m_ready stalls PASS/ABORT; DRAIN discards regardless of m_ready.
module pkt_rr_arb_rollback
  import pkt_arb_pkg::*;
#(
  parameter int D_WIDTH     = 6,
  parameter int MAX_PKT_LEN = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] s0_data,
  input  logic               s0_valid,
  output logic               s0_ready,
  input  logic [D_WIDTH-1:0] s1_data,
  input  logic               s1_valid,
  output logic               s1_ready,
  output logic [D_WIDTH-1:0] m_data,
  output logic               m_valid,
  input  logic               m_ready
`ifdef PKT_ARB_STATS_EN
  ,
  output logic [15:0]        commit_cnt,
  output logic [15:0]        abort_cnt
`endif
);

  localparam int TL_BIT = tlast_bit(D_WIDTH);
  localparam logic [63:0] ABORT_FULL = abort_beat(D_WIDTH);
  localparam logic [D_WIDTH-1:0] ABORT_BEAT = ABORT_FULL[D_WIDTH-1:0];

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_grant_q, last_grant_d;

  logic [D_WIDTH-1:0] sel_data;
  logic               sel_valid;
  logic               sel_last;
  logic               sel_ready;
  logic               xfer_pass;
  logic               xfer_abort;
  logic               len_ovf;

  assign sel_data   = grant_q ? s1_data  : s0_data;
  assign sel_valid  = grant_q ? s1_valid : s0_valid;
  assign sel_last   = sel_data[TL_BIT];
  assign xfer_pass  = (state_q == PASS) && sel_valid && m_ready;
  assign xfer_abort = (state_q == ABORT) && m_ready;

  // Counter is held at zero while idle, so each packet starts from zero.
  pkt_len_watchdog #(
    .MAX_PKT_LEN(MAX_PKT_LEN)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == IDLE),
    .inc_i (xfer_pass),
    .ovf_o (len_ovf)
  );

  // Output steering: only the granted source ever sees ready.
  always_comb begin
    m_data    = '0;
    m_valid   = 1'b0;
    sel_ready = 1'b0;
    case (state_q)
      PASS: begin
        m_data    = sel_data;
        m_valid   = sel_valid;
        sel_ready = m_ready;
      end
      ABORT: begin
        m_data  = ABORT_BEAT;
        m_valid = 1'b1;
      end
      DRAIN: begin
        sel_ready = 1'b1;
      end
      default: ;
    endcase
    s0_ready = sel_ready && !grant_q;
    s1_ready = sel_ready &&  grant_q;
  end

  // Next-state: grant is chosen only in IDLE and held to the end of packet.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (s0_valid || s1_valid) begin
          grant_d = (s0_valid && s1_valid) ? ~last_grant_q : s1_valid;
          state_d = PASS;
        end
      end
      PASS: begin
        if (xfer_pass) begin
          if (sel_last) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
          end else if (len_ovf) begin
            state_d = ABORT;
          end
        end
      end
      ABORT: begin
        if (xfer_abort) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (sel_valid && sel_last) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM registers; last_grant resets to 1 so source 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef PKT_ARB_STATS_EN
  localparam int TU_BIT = tuser_bit(D_WIDTH);

  logic        sel_user;
  logic [15:0] commit_q, abort_q;

  assign sel_user   = sel_data[TU_BIT];
  assign commit_cnt = commit_q;
  assign abort_cnt  = abort_q;

  // Saturating packet outcome counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_q <= '0;
      abort_q  <= '0;
    end else begin
      if (xfer_pass && sel_last && !sel_user && (commit_q != 16'hFFFF)) begin
        commit_q <= commit_q + 16'd1;
      end
      if (((xfer_pass && sel_last && sel_user) || xfer_abort) && (abort_q != 16'hFFFF)) begin
        abort_q <= abort_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pkt_rr_arb_rollback.sv
// Directed bench for pkt_rr_arb_rollback with D_WIDTH=6, MAX_PKT_LEN=4.
// Beat encoding used here: {tuser, tlast, payload[3:0]}, payload bit 3 = source.
// Output beats are collected at the falling edge whenever m_valid && m_ready.
module tb_pkt_rr_arb_rollback;

  logic       clk;
  logic       rst;
  logic [5:0] s0_data, s1_data, m_data;
  logic       s0_valid, s0_ready, s1_valid, s1_ready;
  logic       m_valid, m_ready;
`ifdef PKT_ARB_STATS_EN
  logic [15:0] commit_cnt, abort_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [5:0] q0[$];
  logic [5:0] q1[$];
  logic [5:0] mq[$];
  int         mc[$];
  int         cyc = 0;
  int         rdy_novld = 0;

  pkt_rr_arb_rollback #(
    .D_WIDTH(6),
    .MAX_PKT_LEN(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s0_data  (s0_data),
    .s0_valid (s0_valid),
    .s0_ready (s0_ready),
    .s1_data  (s1_data),
    .s1_valid (s1_valid),
    .s1_ready (s1_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready)
`ifdef PKT_ARB_STATS_EN
    ,
    .commit_cnt (commit_cnt),
    .abort_cnt  (abort_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output monitor: records accepted beats and drain-style cycles.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst && m_valid && m_ready) begin
      mq.push_back(m_data);
      mc.push_back(cyc);
    end
    if (!rst && (s0_ready || s1_ready) && !m_valid) begin
      rdy_novld = rdy_novld + 1;
    end
  end

  task automatic clear_mon();
    mq.delete();
    mc.delete();
    rdy_novld = 0;
  endtask

  task automatic run_src0();
    while (q0.size() > 0) begin
      int t = 0;
      s0_data  = q0[0];
      s0_valid = 1'b1;
      do begin
        @(negedge clk);
        t++;
      end while (!s0_ready && t < 200);
      if (!s0_ready) begin
        checks++;
        errors++;
        $display("FAIL src0_timeout: beat %h never accepted", q0[0]);
        q0.delete();
      end else begin
        @(posedge clk);
        #1;
        void'(q0.pop_front());
      end
    end
    s0_valid = 1'b0;
    s0_data  = '0;
  endtask

  task automatic run_src1();
    while (q1.size() > 0) begin
      int t = 0;
      s1_data  = q1[0];
      s1_valid = 1'b1;
      do begin
        @(negedge clk);
        t++;
      end while (!s1_ready && t < 200);
      if (!s1_ready) begin
        checks++;
        errors++;
        $display("FAIL src1_timeout: beat %h never accepted", q1[0]);
        q1.delete();
      end else begin
        @(posedge clk);
        #1;
        void'(q1.pop_front());
      end
    end
    s1_valid = 1'b0;
    s1_data  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s0_valid = 1'b0; s1_valid = 1'b0;
    s0_data = '0; s1_data = '0;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    checks++; if (m_data !== 6'h00) begin errors++; $display("FAIL rst_m_data: got %h want 00", m_data); end
    checks++; if (s0_ready !== 1'b0) begin errors++; $display("FAIL rst_s0_ready: got %b want 0", s0_ready); end
    checks++; if (s1_ready !== 1'b0) begin errors++; $display("FAIL rst_s1_ready: got %b want 0", s1_ready); end
`ifdef PKT_ARB_STATS_EN
    checks++; if (commit_cnt !== 16'd0) begin errors++; $display("FAIL rst_commit_cnt: got %0d want 0", commit_cnt); end
    checks++; if (abort_cnt !== 16'd0) begin errors++; $display("FAIL rst_abort_cnt: got %0d want 0", abort_cnt); end
`endif
    rst = 1'b0;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL idle_m_valid: got %b want 0", m_valid); end
  endtask

  task automatic test_round_robin();
    logic [5:0] exp[$];
    exp = '{6'h01, 6'h12, 6'h09, 6'h1A, 6'h03, 6'h14, 6'h0B, 6'h1C};
    @(posedge clk); #1;
    clear_mon();
    q0 = '{6'h01, 6'h12, 6'h03, 6'h14};
    q1 = '{6'h09, 6'h1A, 6'h0B, 6'h1C};
    fork
      run_src0();
      run_src1();
    join
    checks++; if (mq.size() !== exp.size()) begin errors++; $display("FAIL rr_count: got %0d want %0d", mq.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      logic [5:0] got;
      got = (i < mq.size()) ? mq[i] : 6'bxxxxxx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL rr_beat%0d: got %h want %h", i, got, exp[i]); end
    end
    if (mc.size() == 8) begin
      checks++; if ((mc[7] - mc[0]) !== 10) begin errors++; $display("FAIL rr_span: got %0d cycles want 10", mc[7] - mc[0]); end
    end
  endtask

  task automatic test_reset_mid_packet();
    int t = 0;
    @(posedge clk); #1;
    q0 = '{6'h11};
    run_src0();
    s0_data = 6'h02;
    s0_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!s0_ready && t < 20);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_m_valid: got %b want 1", m_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_async_m_valid: got %b want 0", m_valid); end
    checks++; if (s0_ready !== 1'b0) begin errors++; $display("FAIL mid_async_s0_ready: got %b want 0", s0_ready); end
    checks++; if (s1_ready !== 1'b0) begin errors++; $display("FAIL mid_async_s1_ready: got %b want 0", s1_ready); end
    s0_valid = 1'b0;
    s0_data = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
`ifdef PKT_ARB_STATS_EN
    checks++; if (commit_cnt !== 16'd0) begin errors++; $display("FAIL mid_commit_cnt: got %0d want 0", commit_cnt); end
`endif
    @(posedge clk); #1;
    clear_mon();
    q0 = '{6'h15};
    q1 = '{6'h1D};
    fork
      run_src0();
      run_src1();
    join
    checks++; if (mq.size() !== 2) begin errors++; $display("FAIL mid_count: got %0d want 2", mq.size()); end
    if (mq.size() == 2) begin
      checks++; if (mq[0] !== 6'h15) begin errors++; $display("FAIL mid_first_grant: got %h want 15", mq[0]); end
      checks++; if (mq[1] !== 6'h1D) begin errors++; $display("FAIL mid_second_grant: got %h want 1d", mq[1]); end
    end
  endtask

  task automatic test_overlong();
    logic [5:0] exp[$];
    exp = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h30, 6'h1F};
    @(posedge clk); #1;
    clear_mon();
    q0 = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h16};
    q1 = '{6'h1F};
    fork
      run_src0();
      run_src1();
    join
    checks++; if (mq.size() !== exp.size()) begin errors++; $display("FAIL ovl_count: got %0d want %0d", mq.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      logic [5:0] got;
      got = (i < mq.size()) ? mq[i] : 6'bxxxxxx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL ovl_beat%0d: got %h want %h", i, got, exp[i]); end
    end
    checks++; if (rdy_novld !== 2) begin errors++; $display("FAIL ovl_drain_cycles: got %0d want 2", rdy_novld); end
  endtask

  task automatic test_exact_max();
    logic [5:0] exp[$];
    exp = '{6'h09, 6'h0A, 6'h0B, 6'h1C};
    @(posedge clk); #1;
    clear_mon();
    q1 = '{6'h09, 6'h0A, 6'h0B, 6'h1C};
    run_src1();
    checks++; if (mq.size() !== 4) begin errors++; $display("FAIL exact_count: got %0d want 4", mq.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      logic [5:0] got;
      got = (i < mq.size()) ? mq[i] : 6'bxxxxxx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL exact_beat%0d: got %h want %h", i, got, exp[i]); end
    end
    checks++; if (rdy_novld !== 0) begin errors++; $display("FAIL exact_no_drain: got %0d want 0", rdy_novld); end
  endtask

  task automatic stall_ctrl();
    int t;
    t = 0;
    do begin @(negedge clk); #1; t++; end while (mq.size() < 2 && t < 100);
    @(posedge clk); #1;
    m_ready = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      checks++; if (s0_ready !== 1'b0) begin errors++; $display("FAIL stall_pass_s0_ready: got %b want 0", s0_ready); end
      checks++; if (m_data !== 6'h03) begin errors++; $display("FAIL stall_pass_m_data: got %h want 03", m_data); end
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    t = 0;
    do begin @(negedge clk); #1; t++; end while (mq.size() < 4 && t < 100);
    @(posedge clk); #1;
    m_ready = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL stall_abort_m_valid: got %b want 1", m_valid); end
      checks++; if (m_data !== 6'h30) begin errors++; $display("FAIL stall_abort_m_data: got %h want 30", m_data); end
      checks++; if (s0_ready !== 1'b0) begin errors++; $display("FAIL stall_abort_s0_ready: got %b want 0", s0_ready); end
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
  endtask

  task automatic test_stall();
    logic [5:0] exp[$];
    exp = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h30};
    @(posedge clk); #1;
    clear_mon();
    q0 = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h15};
    fork
      run_src0();
      stall_ctrl();
    join
    checks++; if (mq.size() !== exp.size()) begin errors++; $display("FAIL stall_count: got %0d want %0d", mq.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      logic [5:0] got;
      got = (i < mq.size()) ? mq[i] : 6'bxxxxxx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL stall_beat%0d: got %h want %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_src_abort();
    @(posedge clk); #1;
    clear_mon();
    q0 = '{6'h01, 6'h35};
    run_src0();
    checks++; if (mq.size() !== 2) begin errors++; $display("FAIL srcab_count: got %0d want 2", mq.size()); end
    if (mq.size() == 2) begin
      checks++; if (mq[1] !== 6'h35) begin errors++; $display("FAIL srcab_passthru: got %h want 35", mq[1]); end
    end
    checks++; if (rdy_novld !== 0) begin errors++; $display("FAIL srcab_no_drain: got %0d want 0", rdy_novld); end
    @(negedge clk);
`ifdef PKT_ARB_STATS_EN
    checks++; if (abort_cnt !== 16'd3) begin errors++; $display("FAIL srcab_abort_cnt: got %0d want 3", abort_cnt); end
    checks++; if (commit_cnt !== 16'd4) begin errors++; $display("FAIL srcab_commit_cnt: got %0d want 4", commit_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_reset_mid_packet();
    test_overlong();
    test_exact_max();
    test_stall();
    test_src_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
